clk_div_checker: RTL
====================

Name: clk_div_checker

Overview:
- Monitor/receiver for the divided clock set derived from clk_32f (clk_f, clk_2f, clk_4f).
- Runs only on clk_32f. Treats the three divided clocks as data inputs and checks their period, duty cycle and phase alignment.
- Reports lock status, error pulses and an error count to PHY control and to the test benches.
- Sits beside the clock generator in the PHY and is also instantiated in benches as a self-check.

Parameters:
- LOCK_PERIODS, 2, number of consecutive clean clk_f periods required before locked asserts. Range 1..15.
- ERR_W, 8, width of the saturating error counter.

Ports:
- clk_32f  input  1  sole clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- clk_f  input  1  divided clock under check; expected 32 clk_32f cycles per period, 16 high and 16 low.
- clk_2f  input  1  divided clock under check; expected 16-cycle period, 8 high and 8 low.
- clk_4f  input  1  divided clock under check; expected 8-cycle period, 4 high and 4 low.
- clr_err  input  1  clears err_count and err_flags.
- locked  output  1  high while state is LOCKED.
- err_pulse  output  1  one-cycle pulse per mismatch detected while LOCKED.
- err_count  output  ERR_W  saturating count of LOCKED mismatches.
- err_flags  output  3  sticky mismatch bits {f, 2f, 4f}.
- phase  output  5  current expected phase within the clk_f period (0..31).

Behaviour:
- Input stage: clk_f, clk_2f and clk_4f are registered once into s_f, s_2f and s_4f. All checks use the registered values.
- Rise detect: rise = s_f & ~s_f_d, where s_f_d is s_f delayed one cycle.
- Expected levels at phase p: clk_f = ~p[4], clk_2f = ~p[3], clk_4f = ~p[2]. All three clocks rise together at p = 0.
- Mismatch vector: mm = {s_f, s_2f, s_4f} XOR expected. It is evaluated only in ACQUIRE and LOCKED.
- Phase counter: increments mod 32 every cycle. In SEARCH, a rise loads phase <= 1, so the rise cycle counts as phase 0.
- State machine: SEARCH, ACQUIRE, LOCKED.
  - SEARCH: no checking, no errors. On rise: go to ACQUIRE, clear period_cnt, set phase <= 1. A stuck clk_f leaves the block in SEARCH indefinitely.
  - ACQUIRE: any mm bit set -> SEARCH and clear period_cnt. At phase 31 with no mismatch, period_cnt++. When period_cnt reaches LOCK_PERIODS -> LOCKED.
  - LOCKED: any mm bit set -> SEARCH. On the next cycle: err_pulse = 1, err_flags |= mm, err_count increments (saturates at all ones).
- locked: registered decode of state == LOCKED. It drops in the same cycle err_pulse rises.
- Lock latency (LOCK_PERIODS = 2, clean input): locked asserts 64 cycles after the SEARCH cycle in which rise is seen.
- Missing or early clk_f edge: caught by the level compare, no separate timeout.
  - A rise at the wrong phase is a clk_f mismatch.
  - A missing rise at phase 0 is also a clk_f mismatch.
- clr_err: clears err_count and err_flags on the next edge.
  - clr_err together with a new error: the error wins; err_count = 1 and err_flags = mm.
- Reset: effective on the next edge, including mid-operation.
  - state = SEARCH; phase, period_cnt, input registers, err_count and err_flags = 0.
  - locked = 0, err_pulse = 0.

Test Plan:
- Clean divided clocks (clk_4f rises with clk_f), LOCK_PERIODS = 2 -> locked rises exactly 64 cycles after the rise-detect cycle; err_count stays 0 over 1000 cycles.
- While locked, invert clk_4f for one cycle at phase 5 -> err_pulse one cycle, err_flags = 3'b001, err_count = 1, locked = 0; relock after a further 64+ cycles.
- Shift clk_2f by one clk_32f cycle while locked -> err_flags bit1 set; the block stays cycling SEARCH/ACQUIRE and never re-locks while the skew persists.
- Force ERR_W = 2 and inject 5 locked errors, with relock between each -> err_count saturates at 3. Then clr_err pulsed together with a 6th error -> err_count = 1.
- Hold clk_f low after reset -> block stays in SEARCH; locked = 0, err_pulse never asserts.
- Assert reset for one cycle while locked with err_count = 2 -> next cycle locked = 0, err_count = 0, err_flags = 0, phase = 0.

Source files
------------

// File: rtl/clk_div_checker.sv
`default_nettype none
// ============================================================================
// Module   : clk_div_checker
// Purpose  : Checks period, duty and phase of clk_f/clk_2f/clk_4f against clk_32f.
// Revision : 1.0
// ============================================================================
module clk_div_checker #(
    parameter int LOCK_PERIODS = 2,
    parameter int ERR_W        = 8
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             clk_f,
    input  logic             clk_2f,
    input  logic             clk_4f,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_count,
    output logic [2:0]       err_flags,
    output logic [4:0]       phase
);

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0]       C_LOCK_PERIODS = 4'(LOCK_PERIODS);
    localparam logic [ERR_W-1:0] C_ERR_MAX      = '1;
    localparam logic [ERR_W-1:0] C_ERR_ONE      = ERR_W'(1);

    state_t     r_state;
    state_t     w_state_next;
    logic       r_s_f;
    logic       r_s_2f;
    logic       r_s_4f;
    logic       r_s_f_d;
    logic [4:0] r_phase;
    logic [3:0] r_period_cnt;
    logic [3:0] w_period_next;
    logic       w_phase_load;
    logic       w_rise;
    logic [2:0] w_expected;
    logic [2:0] w_mm;
    logic       w_mm_any;
    logic       w_lock_err;

    assign w_rise     = r_s_f & ~r_s_f_d;
    // All three clocks are high in the first half of their own period.
    assign w_expected = {~r_phase[4], ~r_phase[3], ~r_phase[2]};
    assign w_mm       = (r_state == SEARCH) ? 3'b000
                                            : ({r_s_f, r_s_2f, r_s_4f} ^ w_expected);
    assign w_mm_any   = |w_mm;
    assign w_lock_err = (r_state == LOCKED) && w_mm_any;
    assign phase      = r_phase;

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_state <= SEARCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_period_next = r_period_cnt;
        w_phase_load  = 1'b0;
        case (r_state)
            SEARCH: begin
                if (w_rise) begin
                    w_state_next  = ACQUIRE;
                    w_period_next = 4'd0;
                    w_phase_load  = 1'b1;
                end
            end
            ACQUIRE: begin
                if (w_mm_any) begin
                    w_state_next  = SEARCH;
                    w_period_next = 4'd0;
                end else if (r_phase == 5'd31) begin
                    w_period_next = r_period_cnt + 4'd1;
                    if (r_period_cnt + 4'd1 == C_LOCK_PERIODS) begin
                        w_state_next = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (w_mm_any) begin
                    w_state_next = SEARCH;
                end
            end
            default: begin
                w_state_next = SEARCH;
            end
        endcase
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_s_f        <= 1'b0;
            r_s_2f       <= 1'b0;
            r_s_4f       <= 1'b0;
            r_s_f_d      <= 1'b0;
            r_phase      <= 5'd0;
            r_period_cnt <= 4'd0;
            locked       <= 1'b0;
            err_pulse    <= 1'b0;
            err_count    <= '0;
            err_flags    <= 3'b000;
        end else begin
            r_s_f        <= clk_f;
            r_s_2f       <= clk_2f;
            r_s_4f       <= clk_4f;
            r_s_f_d      <= r_s_f;
            // The rise cycle itself is phase 0, so the next one is 1.
            r_phase      <= w_phase_load ? 5'd1 : r_phase + 5'd1;
            r_period_cnt <= w_period_next;
            locked       <= (w_state_next == LOCKED);
            err_pulse    <= w_lock_err;
            if (w_lock_err) begin
                // A new error overrides a simultaneous clear.
                if (clr_err) begin
                    err_count <= C_ERR_ONE;
                    err_flags <= w_mm;
                end else begin
                    err_flags <= err_flags | w_mm;
                    if (err_count != C_ERR_MAX) begin
                        err_count <= err_count + C_ERR_ONE;
                    end
                end
            end else if (clr_err) begin
                err_count <= '0;
                err_flags <= 3'b000;
            end
        end
    end

endmodule
`default_nettype wire
